// File: rtl/door_pkg.sv
// Shared types and constants for the door access controller.
// State encodings are fixed because state_o exposes them to the outside world.
package door_pkg;

  localparam int STATE_W = 3;
  localparam int FAIL_W  = 4;

  localparam int MASTER_DEFAULT = 1111;

  typedef enum logic [STATE_W-1:0] {
    ST_LOCKED   = 3'd0,
    ST_MENU     = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_ALARM    = 3'd3,
    ST_PROGRAM  = 3'd4
  } state_t;

  // Counter that sticks at its all-ones value instead of wrapping.
  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] value);
    return (value == '1) ? value : value + FAIL_W'(1);
  endfunction

endpackage

// File: rtl/door_access_ctrl_if.sv
// Keypad/programming requests and actuator outputs of the door controller.
// The slave side belongs to the controller, the master side to the surrounding system.
interface door_access_ctrl_if
  import door_pkg::*;
#(
  parameter int PW_W = 14,
  parameter int UW   = 2
);

  logic                code_valid;
  logic [PW_W-1:0]     code_in;
  logic [UW-1:0]       user_sel;
  logic                unlock_req;
  logic                lock_req;
  logic                prog_req;
  logic                prog_commit;
  logic [PW_W-1:0]     prog_code;
  logic                menu_exit;

  logic                unlock_signal;
  logic                lock_signal;
  logic                alarm_signal;
  logic                prog_ack;
  logic                prog_nack;
  logic [FAIL_W-1:0]   fail_count;
  logic [STATE_W-1:0]  state_o;

  modport master (
    output code_valid, code_in, user_sel, unlock_req, lock_req,
           prog_req, prog_commit, prog_code, menu_exit,
    input  unlock_signal, lock_signal, alarm_signal, prog_ack,
           prog_nack, fail_count, state_o
  );

  modport slave (
    input  code_valid, code_in, user_sel, unlock_req, lock_req,
           prog_req, prog_commit, prog_code, menu_exit,
    output unlock_signal, lock_signal, alarm_signal, prog_ack,
           prog_nack, fail_count, state_o
  );

endinterface

// File: rtl/door_code_store.sv
// Register file of programmable user codes with a single write port
// and a combinational compare against the selected slot.
module door_code_store
  import door_pkg::*;
#(
  parameter int              PW_W         = 14,
  parameter int              NUM_USERS    = 4,
  parameter int              UW           = 2,
  parameter logic [PW_W-1:0] DEFAULT_CODE = PW_W'(1234)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [UW-1:0]   wr_sel,
  input  logic [PW_W-1:0] wr_code,
  input  logic [UW-1:0]   cmp_sel,
  input  logic [PW_W-1:0] cmp_code,
  output logic            match
);

  logic [PW_W-1:0] slots [NUM_USERS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_USERS; i++) begin
        slots[i] <= (i == 0) ? DEFAULT_CODE : '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_USERS; i++) begin
        if (wr_sel == UW'(i)) begin
          slots[i] <= wr_code;
        end
      end
    end
  end

  // A zero slot is disabled; selectors beyond NUM_USERS hit no slot at all.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_USERS; i++) begin
      if (cmp_sel == UW'(i) && slots[i] != '0 && slots[i] == cmp_code) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/door_access_ctrl.sv
// Multi-user door controller: code check, lockout alarm, auto-relock
// timer and per-slot code programming with accept/reject pulses.
module door_access_ctrl
  import door_pkg::*;
#(
  parameter int              PW_W          = 14,
  parameter int              NUM_USERS     = 4,
  parameter logic [PW_W-1:0] MASTER_CODE   = PW_W'(MASTER_DEFAULT),
  parameter logic [PW_W-1:0] DEFAULT_CODE  = PW_W'(1234),
  parameter int              MAX_FAILS     = 3,
  parameter int              ALARM_CYCLES  = 16,
  parameter int              RELOCK_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  door_access_ctrl_if.slave bus
);

  localparam int UW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
  localparam int AW = $clog2(ALARM_CYCLES + 1);
  localparam int RW = $clog2(RELOCK_CYCLES + 1);
  localparam logic [UW:0] USER_LIMIT = (UW + 1)'(NUM_USERS);

  state_t            state, state_nx;
  logic [FAIL_W-1:0] fail_count, fail_nx, fail_inc;
  logic [AW-1:0]     alarm_timer, alarm_nx;
  logic [RW-1:0]     relock_timer, relock_nx;
  logic              is_master, master_nx;
  logic [UW-1:0]     auth_slot, auth_nx;
  logic              ack, ack_nx, nack, nack_nx;
  logic              wr_en, slot_match, sel_in_range, prog_ok;

  door_code_store #(
    .PW_W         (PW_W),
    .NUM_USERS    (NUM_USERS),
    .UW           (UW),
    .DEFAULT_CODE (DEFAULT_CODE)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (bus.user_sel),
    .wr_code  (bus.prog_code),
    .cmp_sel  (bus.user_sel),
    .cmp_code (bus.code_in),
    .match    (slot_match)
  );

  assign fail_inc     = sat_inc(fail_count);
  assign sel_in_range = {1'b0, bus.user_sel} < USER_LIMIT;

  // Non-master users may only rewrite the slot they logged in with.
  assign prog_ok = sel_in_range
                && bus.prog_code != MASTER_CODE
                && bus.prog_code != '0
                && (is_master || bus.user_sel == auth_slot);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_LOCKED;
      fail_count   <= '0;
      alarm_timer  <= '0;
      relock_timer <= '0;
      is_master    <= 1'b0;
      auth_slot    <= '0;
      ack          <= 1'b0;
      nack         <= 1'b0;
    end else begin
      state        <= state_nx;
      fail_count   <= fail_nx;
      alarm_timer  <= alarm_nx;
      relock_timer <= relock_nx;
      is_master    <= master_nx;
      auth_slot    <= auth_nx;
      ack          <= ack_nx;
      nack         <= nack_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    fail_nx   = fail_count;
    alarm_nx  = alarm_timer;
    relock_nx = relock_timer;
    master_nx = is_master;
    auth_nx   = auth_slot;
    ack_nx    = 1'b0;
    nack_nx   = 1'b0;
    wr_en     = 1'b0;

    case (state)
      ST_LOCKED: begin
        if (bus.code_valid) begin
          if (bus.code_in == MASTER_CODE || slot_match) begin
            state_nx  = ST_MENU;
            fail_nx   = '0;
            master_nx = (bus.code_in == MASTER_CODE);
            auth_nx   = bus.user_sel;
          end else begin
            fail_nx = fail_inc;
            if (fail_inc == FAIL_W'(MAX_FAILS)) begin
              state_nx = ST_ALARM;
              alarm_nx = AW'(ALARM_CYCLES - 1);
            end
          end
        end
      end

      ST_MENU: begin
        if (bus.menu_exit) begin
          state_nx = ST_LOCKED;
        end else if (bus.prog_req) begin
          state_nx = ST_PROGRAM;
        end else if (bus.unlock_req) begin
          state_nx  = ST_UNLOCKED;
          relock_nx = RW'(RELOCK_CYCLES - 1);
        end
      end

      ST_UNLOCKED: begin
        if (bus.lock_req || relock_timer == '0) begin
          state_nx = ST_LOCKED;
        end else begin
          relock_nx = relock_timer - RW'(1);
        end
      end

      // Every input, the master code included, is ignored until the timer runs out.
      ST_ALARM: begin
        if (alarm_timer == '0) begin
          state_nx = ST_LOCKED;
          fail_nx  = '0;
        end else begin
          alarm_nx = alarm_timer - AW'(1);
        end
      end

      ST_PROGRAM: begin
        if (bus.menu_exit) begin
          state_nx = ST_LOCKED;
        end else if (bus.prog_commit) begin
          if (prog_ok) begin
            wr_en    = 1'b1;
            ack_nx   = 1'b1;
            state_nx = ST_MENU;
          end else begin
            nack_nx = 1'b1;
          end
        end
      end

      default: state_nx = ST_LOCKED;
    endcase
  end

  assign bus.unlock_signal = (state == ST_UNLOCKED);
  assign bus.lock_signal   = (state != ST_UNLOCKED);
  assign bus.alarm_signal  = (state == ST_ALARM);
  assign bus.prog_ack      = ack;
  assign bus.prog_nack     = nack;
  assign bus.fail_count    = fail_count;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed bench for door_access_ctrl: vector tables for single-cycle steps,
// hand-written sequences for timer lengths and asynchronous reset.
module tb_door_access_ctrl;

  typedef struct {
    logic        cv;
    logic [13:0] code;
    logic [1:0]  sel;
    logic        unl;
    logic        lck;
    logic        prg;
    logic        cmt;
    logic [13:0] pcode;
    logic        mex;
    int          st;
    int          fc;
    logic        ack;
    logic        nack;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;
  vec_t tbl[$];

  door_access_ctrl_if #(.PW_W(14), .UW(2)) bus ();

  door_access_ctrl #(
    .PW_W(14), .NUM_USERS(4), .MASTER_CODE(14'd1111), .DEFAULT_CODE(14'd1234),
    .MAX_FAILS(3), .ALARM_CYCLES(16), .RELOCK_CYCLES(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t v_none();
    vec_t v;
    v.cv = 0; v.code = '0; v.sel = '0; v.unl = 0; v.lck = 0; v.prg = 0;
    v.cmt = 0; v.pcode = '0; v.mex = 0; v.st = 0; v.fc = 0; v.ack = 0; v.nack = 0;
    return v;
  endfunction

  function automatic vec_t v_code(int code, int sel, int st, int fc);
    vec_t v = v_none();
    v.cv = 1; v.code = 14'(code); v.sel = 2'(sel); v.st = st; v.fc = fc;
    return v;
  endfunction

  function automatic vec_t v_ctl(logic unl, logic lck, logic prg, logic mex, int st, int fc);
    vec_t v = v_none();
    v.unl = unl; v.lck = lck; v.prg = prg; v.mex = mex; v.st = st; v.fc = fc;
    return v;
  endfunction

  function automatic vec_t v_commit(int sel, int pcode, logic mex, int st, logic ack, logic nack);
    vec_t v = v_none();
    v.cmt = 1; v.sel = 2'(sel); v.pcode = 14'(pcode); v.mex = mex; v.st = st;
    v.ack = ack; v.nack = nack;
    return v;
  endfunction

  task automatic drive_idle();
    bus.code_valid = 0; bus.code_in = '0; bus.user_sel = '0; bus.unlock_req = 0;
    bus.lock_req = 0; bus.prog_req = 0; bus.prog_commit = 0; bus.prog_code = '0;
    bus.menu_exit = 0;
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Lock/unlock/alarm expectations follow from the expected state.
  task automatic check_outputs(input int st, input int fc, input logic ack, input logic nack,
                               input string tag);
    check_val({tag, ".state"},  int'(bus.state_o), st);
    check_val({tag, ".fails"},  int'(bus.fail_count), fc);
    check_val({tag, ".ack"},    int'(bus.prog_ack), int'(ack));
    check_val({tag, ".nack"},   int'(bus.prog_nack), int'(nack));
    check_val({tag, ".unlock"}, int'(bus.unlock_signal), (st == 2) ? 1 : 0);
    check_val({tag, ".lock"},   int'(bus.lock_signal), (st == 2) ? 0 : 1);
    check_val({tag, ".alarm"},  int'(bus.alarm_signal), (st == 3) ? 1 : 0);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    bus.code_valid = v.cv; bus.code_in = v.code; bus.user_sel = v.sel;
    bus.unlock_req = v.unl; bus.lock_req = v.lck; bus.prog_req = v.prg;
    bus.prog_commit = v.cmt; bus.prog_code = v.pcode; bus.menu_exit = v.mex;
    @(posedge clk); #1;
    drive_idle();
    check_outputs(v.st, v.fc, v.ack, v.nack, tag);
  endtask

  task automatic run_table(input string phase);
    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("%s[%0d]", phase, i));
    tbl.delete();
  endtask

  initial begin
    int cnt;
    int guard;

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_outputs(0, 0, 0, 0, "reset");

    // Master login then unlock; relock length measured by hand below.
    tbl.push_back(v_code(1111, 0, 1, 0));
    tbl.push_back(v_ctl(1, 0, 0, 0, 2, 0));
    run_table("unlock");
    cnt = 1;
    guard = 0;
    while (bus.unlock_signal && guard < 20) begin
      @(posedge clk); #1;
      if (bus.unlock_signal) cnt++;
      guard++;
    end
    check_val("relock_len", cnt, 8);
    check_outputs(0, 0, 0, 0, "relocked");

    // Programming, permission rules, and the three-strike lockout.
    tbl.push_back(v_code(1111, 0, 1, 0));
    tbl.push_back(v_ctl(0, 0, 1, 0, 4, 0));
    tbl.push_back(v_commit(2, 2222, 0, 1, 1, 0));
    tbl.push_back(v_ctl(0, 0, 0, 0, 1, 0));
    tbl.push_back(v_ctl(0, 0, 0, 1, 0, 0));
    tbl.push_back(v_code(2222, 2, 1, 0));
    tbl.push_back(v_ctl(0, 0, 0, 1, 0, 0));
    tbl.push_back(v_code(2222, 1, 0, 1));
    tbl.push_back(v_code(1234, 0, 1, 0));
    tbl.push_back(v_ctl(0, 0, 1, 0, 4, 0));
    tbl.push_back(v_commit(1, 2222, 0, 4, 0, 1));
    tbl.push_back(v_commit(0, 1111, 0, 4, 0, 1));
    tbl.push_back(v_commit(0, 0, 0, 4, 0, 1));
    tbl.push_back(v_commit(0, 4321, 0, 1, 1, 0));
    tbl.push_back(v_ctl(0, 0, 0, 1, 0, 0));
    tbl.push_back(v_code(1234, 0, 0, 1));
    tbl.push_back(v_code(4321, 0, 1, 0));
    tbl.push_back(v_ctl(0, 0, 0, 1, 0, 0));
    tbl.push_back(v_code(3333, 0, 0, 1));
    tbl.push_back(v_code(3333, 0, 0, 2));
    tbl.push_back(v_code(3333, 0, 3, 3));
    run_table("prog");

    cnt = 1;
    guard = 0;
    while (bus.alarm_signal && guard < 40) begin
      if (guard == 0) begin
        bus.code_valid = 1; bus.code_in = 14'd1111;
      end
      @(posedge clk); #1;
      drive_idle();
      if (guard == 0) check_val("alarm_ignores_master", int'(bus.state_o), 3);
      if (bus.alarm_signal) cnt++;
      guard++;
    end
    check_val("alarm_len", cnt, 16);
    check_outputs(0, 0, 0, 0, "post_alarm");

    // Menu priorities, aborted write, forced relock.
    tbl.push_back(v_code(1111, 0, 1, 0));
    tbl.push_back(v_ctl(1, 0, 1, 1, 0, 0));
    tbl.push_back(v_code(1111, 0, 1, 0));
    tbl.push_back(v_ctl(1, 0, 1, 0, 4, 0));
    tbl.push_back(v_commit(3, 5555, 1, 0, 0, 0));
    tbl.push_back(v_code(5555, 3, 0, 1));
    tbl.push_back(v_code(1111, 0, 1, 0));
    tbl.push_back(v_ctl(1, 0, 0, 0, 2, 0));
    tbl.push_back(v_ctl(0, 1, 0, 0, 0, 0));
    tbl.push_back(v_code(1111, 0, 1, 0));
    tbl.push_back(v_ctl(1, 0, 0, 0, 2, 0));
    run_table("prio");

    // Asynchronous reset while unlocked takes effect before the next edge.
    #2 reset = 1'b1;
    #1 check_outputs(0, 0, 0, 0, "reset_unlocked");
    #3 reset = 1'b0;
    @(posedge clk); #1;

    tbl.push_back(v_code(1111, 0, 1, 0));
    tbl.push_back(v_ctl(0, 0, 1, 0, 4, 0));
    run_table("enter_prog");

    // Reset lands on top of a pending commit; the write must be lost.
    bus.prog_commit = 1; bus.user_sel = 2'd2; bus.prog_code = 14'd6666;
    #2 reset = 1'b1;
    #1 check_outputs(0, 0, 0, 0, "reset_prog");
    @(posedge clk); #1;
    drive_idle();
    check_outputs(0, 0, 0, 0, "reset_prog_hold");
    #2 reset = 1'b0;
    @(posedge clk); #1;

    tbl.push_back(v_code(2222, 2, 0, 1));
    tbl.push_back(v_code(6666, 2, 0, 2));
    tbl.push_back(v_code(1234, 0, 1, 0));
    run_table("after_reset");

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
